// File: rtl/keypad_emulator.sv
// keypad_emulator: responder end of a 4x4 row-scan/column-sense keypad.
// A press is requested through req/busy/done. Each press optionally has
// LFSR-driven contact bounce before and after a clean hold interval.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned HOLD_W        = 25,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        r,
  output logic [3:0]        c,
  input  logic              req,
  input  logic [3:0]        key,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              bounce_en,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              contact
);

  // One counter serves both the bounce windows and the hold interval.
  localparam int unsigned BC_W  = $clog2(BOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W = (HOLD_W > BC_W) ? HOLD_W : BC_W;
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_BOUNCE,
    S_HOLD,
    S_RELEASE_BOUNCE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         key_q, key_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               bounce_en_q, bounce_en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               contact_q, contact_d;

  logic [CNT_W-1:0]   hold_last;
  state_t             end_target;

  // State register and latched press parameters; reset abandons any press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      key_q       <= 4'd0;
      hold_q      <= '0;
      bounce_en_q <= 1'b0;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      contact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      hold_q      <= hold_d;
      bounce_en_q <= bounce_en_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      contact_q   <= contact_d;
    end
  end

  // Next-state logic; contact is registered as the value the next state shows.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    hold_d      = hold_q;
    bounce_en_d = bounce_en_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    contact_d   = 1'b0;
    // hold_q is never zero once latched, so this cannot underflow
    hold_last   = CNT_W'(hold_q) - CNT_W'(1);
    end_target  = bounce_en_q ? S_RELEASE_BOUNCE : S_DONE;

    // Taps 8,6,5,4; the LFSR only advances while a bounce window is active
    if (state_q == S_PRESS_BOUNCE || state_q == S_RELEASE_BOUNCE) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    case (state_q)
      S_IDLE: begin
        if (req) begin
          key_d       = key;
          hold_d      = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
          bounce_en_d = bounce_en;
          cnt_d       = '0;
          state_d     = bounce_en ? S_PRESS_BOUNCE : S_HOLD;
        end
      end
      S_PRESS_BOUNCE: begin
        if (abort) begin
          state_d = end_target;
          cnt_d   = '0;
        end else if (cnt_q == BOUNCE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        // Equality check before increment keeps the maximum hold from wrapping
        if (abort || cnt_q == hold_last) begin
          state_d = end_target;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE_BOUNCE: begin
        if (cnt_q == BOUNCE_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_PRESS_BOUNCE, S_RELEASE_BOUNCE: contact_d = lfsr_d[0];
      S_HOLD:                           contact_d = 1'b1;
      default:                          contact_d = 1'b0;
    endcase
  end

  // Zero-latency switch path: column follows the selected row while closed.
  always_comb begin
    c = 4'b0000;
    if (contact_q && r[key_q[3:2]]) begin
      c = 4'b0001 << key_q[1:0];
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign contact = contact_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Testbench for keypad_emulator: each press is described as a list of
// per-cycle expected {contact,busy,done} values built from the press rules.
module tb_keypad_emulator;

  localparam int BOUNCE = 64;
  localparam int HW     = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    r;
  logic [3:0]    c;
  logic          req;
  logic [3:0]    key;
  logic [HW-1:0] hold_cycles;
  logic          bounce_en;
  logic          abort;
  logic          busy;
  logic          done;
  logic          contact;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [7:0]    lfsr_m;
  logic [2:0]    exp_q[$];

  keypad_emulator #(
    .BOUNCE_CYCLES(BOUNCE),
    .HOLD_W       (HW),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .r          (r),
    .c          (c),
    .req        (req),
    .key        (key),
    .hold_cycles(hold_cycles),
    .bounce_en  (bounce_en),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .contact    (contact)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Polynomial x^8+x^6+x^5+x^4: feedback is parity of bits 7,5,4,3.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'b1011_1000)};
  endfunction

  // Append the expected trace of one press (cycles 1..end, then one IDLE cycle).
  function automatic void append_press(input int hold, input bit ben, input int abort_at);
    int  h;
    int  t;
    bit  aborted;
    h = (hold < 1) ? 1 : hold;
    t = 1;
    aborted = 0;
    if (ben) begin
      for (int i = 0; i < BOUNCE && !aborted; i++) begin
        exp_q.push_back({lfsr_m[0], 1'b1, 1'b0});
        lfsr_m = lfsr_step(lfsr_m);
        if (t == abort_at) aborted = 1;
        t++;
      end
    end
    for (int i = 0; i < h && !aborted; i++) begin
      exp_q.push_back(3'b110);
      if (t == abort_at) aborted = 1;
      t++;
    end
    if (ben) begin
      for (int i = 0; i < BOUNCE; i++) begin
        exp_q.push_back({lfsr_m[0], 1'b1, 1'b0});
        lfsr_m = lfsr_step(lfsr_m);
      end
    end
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pick_r(input int mode, input int t);
    logic [3:0] v;
    case (mode)
      0:       v = 4'b0001 << (t % 4);
      1:       v = 4'b0001 << $urandom_range(0, 3);
      default: v = 4'($urandom);
    endcase
    return v;
  endfunction

  // Drive one press and check every cycle of it against the model trace.
  task automatic run_press(input logic [3:0] k, input int hold, input bit ben,
                           input int abort_at, input int r_mode, input bit noisy,
                           input string name);
    logic [2:0] e;
    logic [3:0] ec;
    int         dones;
    int         n;
    bit         last;
    exp_q.delete();
    append_press(hold, ben, abort_at);
    n = exp_q.size();
    req = 1'b1; key = k; hold_cycles = HW'(hold); bounce_en = ben; abort = 1'b0;
    dones = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      last = (t == n);
      req = noisy && !last;
      if (noisy) begin
        key = 4'hF;
        hold_cycles = HW'($urandom_range(0, 7));
        bounce_en = 1'($urandom);
      end
      abort = (t == abort_at);
      r = pick_r(r_mode, t);
      #3;
      e  = exp_q[t-1];
      ec = (e[2] && r[k[3:2]]) ? (4'b0001 << k[1:0]) : 4'b0000;
      n_tests++;
      if ({contact, busy, done, c} !== {e, ec}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {contact,busy,done,c} got %b required %b",
                 name, t, {contact, busy, done, c}, {e, ec});
      end
      if (done === 1'b1) dones++;
    end
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d required 1", name, dones);
    end
    abort = 1'b0;
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; key = 4'h0; hold_cycles = '0;
    bounce_en = 1'b0; abort = 1'b0; r = 4'b1111;
    #12;
    n_tests++;
    if ({c, busy, done, contact} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", {c, busy, done, contact}, 7'b0);
    end
    tick();
    reset = 1'b0;
    lfsr_m = 8'hA5;
    tick();
    n_tests++;
    if ({c, busy, done, contact} !== 7'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required %b", {c, busy, done, contact}, 7'b0);
    end
  endtask

  task automatic test_clean_press();
    run_press(4'b0110, 10, 1'b0, -1, 0, 1'b0, "clean_press");
  endtask

  task automatic test_bounce_press();
    run_press(4'hB, 100, 1'b1, -1, 1, 1'b0, "bounce_press");
  endtask

  task automatic test_abort();
    run_press(4'h5, 1000, 1'b0, 20, 1, 1'b0, "abort_hold");
    run_press(4'hE, 5, 1'b1, 30, 2, 1'b0, "abort_press_bounce");
  endtask

  task automatic test_ignored_request();
    run_press(4'h3, 12, 1'b0, -1, 2, 1'b1, "ignored_req");
    run_press(4'hC, 0, 1'b0, -1, 0, 1'b0, "hold_zero");
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    logic [3:0] ec;
    int         n;
    exp_q.delete();
    append_press(3, 1'b0, -1);
    append_press(3, 1'b0, -1);
    n = exp_q.size();
    req = 1'b1; key = 4'h7; hold_cycles = HW'(3); bounce_en = 1'b0;
    for (int t = 1; t <= n + 1; t++) begin
      tick();
      req = (t <= 5);
      r = pick_r(0, t);
      #3;
      e  = (t <= n) ? exp_q[t-1] : 3'b000;
      ec = (e[2] && r[1]) ? 4'b1000 : 4'b0000;
      n_tests++;
      if ({contact, busy, done, c} !== {e, ec}) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: {contact,busy,done,c} got %b required %b",
                 t, {contact, busy, done, c}, {e, ec});
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid_press();
    logic [3:0] k;
    int         dones;
    k = 4'h9;
    req = 1'b1; key = k; hold_cycles = HW'(1000); bounce_en = 1'b0;
    tick();
    req = 1'b0;
    r = 4'b0001 << k[3:2];
    for (int i = 0; i < 4; i++) tick();
    #3;
    n_tests++;
    if (c !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_press_c: got %b required %b", c, 4'b0010);
    end
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({c, busy, done, contact} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset_drop: got %b required %b", {c, busy, done, contact}, 7'b0);
    end
    tick();
    tick();
    reset = 1'b0;
    lfsr_m = 8'hA5;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #3;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got %0d busy/done cycles required 0", dones);
    end
    run_press(4'h9, 6, 1'b1, -1, 1, 1'b0, "press_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_press(4'($urandom), $urandom_range(0, 20), 1'($urandom),
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 90) : -1,
                2, 1'b1, $sformatf("random_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_abort();
    test_ignored_request();
    test_back_to_back();
    test_reset_mid_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
